// File: rtl/uart_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_rx_if                                                        |
// | Brief  : Serial-in / byte-stream-out port bundle of the UART receiver.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  // Driver of the line and consumer of the bytes.
  modport master (
    output rx,
    output ready,
    input  data,
    input  valid,
    input  frame_err,
    input  overrun
  );

  // The receiver itself.
  modport slave (
    input  rx,
    input  ready,
    output data,
    output valid,
    output frame_err,
    output overrun
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_rx                                                           |
// | Brief  : 8N1 UART receiver with show-ahead receive FIFO and error pulses.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  wire logic clk,
  input  wire logic rst,
  uart_rx_if.slave  bus
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT) + 1;
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);

  localparam logic [c_cnt_w-1:0] c_half_m1 = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_full_m1 = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  // Synchronizer
  logic r_rx_meta;
  logic r_rx_s;

  // Receive FSM
  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_frame_err;

  // Receive FIFO
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               r_overrun;

  logic w_stop_sample;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_valid;
  logic w_wr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_stop_sample = (r_state == STOP) && (r_cnt == c_full_m1);
  // A good stop bit pushes the assembled byte in the very cycle it is sampled.
  assign w_push        = w_stop_sample && r_rx_s;
  assign w_valid       = (r_count != '0);
  assign w_pop         = w_valid && bus.ready;
  assign w_full        = (r_count == c_depth);
  assign w_wr_en       = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_rx_s) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end

        START: begin
          // Mid-start-bit check: a line already back high was only a glitch.
          if (r_cnt == c_half_m1) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= r_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end

        DATA: begin
          if (r_cnt == c_full_m1) begin
            r_cnt     <= '0;
            r_shift   <= {r_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end

        STOP: begin
          if (w_stop_sample) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_state <= IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end

        WAIT_IDLE: begin
          // A held-low line (break) parks here so it reports only once.
          if (r_rx_s) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_overrun <= w_push && w_full && !w_pop;
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.data      = r_mem[r_rd_ptr];
  assign bus.valid     = w_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_uart_rx                                                        |
// | Brief  : Directed self-checking bench for uart_rx (8 clk/bit, depth 4).    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_uart_rx;

  localparam int c_cpb = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [7:0] rxq[$];
  int         valid_cycles;
  int         fe_cnt;
  int         ov_cnt;

  uart_rx_if u_if ();

  uart_rx #(
    .CLKS_PER_BIT(c_cpb),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observes outputs mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (u_if.valid) valid_cycles++;
    if (u_if.valid && u_if.ready) rxq.push_back(u_if.data);
    if (u_if.frame_err) fe_cnt++;
    if (u_if.overrun) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got(input int i);
    return (i < rxq.size()) ? 32'(rxq[i]) : 32'hFFFF;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    rxq.delete();
    valid_cycles = 0;
    fe_cnt       = 0;
    ov_cnt       = 0;
  endtask

  // Frame starts right after the call; stop bit level is selectable.
  task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
    logic [9:0] f;
    f = {stop_lvl, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      u_if.rx = f[i];
      idle(c_cpb);
    end
  endtask

  logic [7:0] fb [10];

  initial begin
    checks = 0;
    errors = 0;
    fb = '{8'h46, 8'h69, 8'h7A, 8'h7A, 8'h42, 8'h75, 8'h7A, 8'h7A, 8'h0D, 8'h0A};
    rst        = 1'b1;
    u_if.rx    = 1'b1;
    u_if.ready = 1'b0;
    clr();
    idle(3);
    chk("rst_valid", 32'(u_if.valid), 0);
    chk("rst_data", 32'(u_if.data), 0);
    chk("rst_frame_err", 32'(u_if.frame_err), 0);
    chk("rst_overrun", 32'(u_if.overrun), 0);
    rst = 1'b0;
    idle(5);

    // Single byte with exact push latency.
    clr();
    u_if.ready = 1'b1;
    fork
      send_byte(8'h46, 1'b1);
      begin
        idle(78);
        chk("f_valid_before", 32'(u_if.valid), 0);
        idle(1);
        chk("f_valid_after", 32'(u_if.valid), 1);
        chk("f_data", 32'(u_if.data), 32'h46);
      end
    join
    idle(10);
    chk("f_count", rxq.size(), 1);
    chk("f_byte", got(0), 32'h46);
    chk("f_valid_cycles", valid_cycles, 1);
    chk("f_fe", fe_cnt, 0);
    chk("f_ov", ov_cnt, 0);

    // Back-to-back string.
    clr();
    for (int i = 0; i < 10; i++) send_byte(fb[i], 1'b1);
    idle(20);
    chk("fb_count", rxq.size(), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("fb_byte%0d", i), got(i), 32'(fb[i]));
    chk("fb_fe", fe_cnt, 0);
    chk("fb_ov", ov_cnt, 0);

    // Overrun on the fifth byte, then drain.
    clr();
    u_if.ready = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'h31 + 8'(i), 1'b1);
    idle(20);
    chk("ov_pulses", ov_cnt, 1);
    chk("ov_fe", fe_cnt, 0);
    chk("ov_valid_held", 32'(u_if.valid), 1);
    chk("ov_data_held", 32'(u_if.data), 32'h31);
    u_if.ready = 1'b1;
    idle(10);
    chk("ov_drain_count", rxq.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("ov_drain%0d", i), got(i), 32'h31 + i);
    chk("ov_valid_drop", 32'(u_if.valid), 0);

    // Stop bit low for one bit time, then a good byte.
    clr();
    send_byte(8'h55, 1'b0);
    u_if.rx = 1'b1;
    idle(16);
    send_byte(8'hAA, 1'b1);
    idle(20);
    chk("fe_pulses", fe_cnt, 1);
    chk("fe_ov", ov_cnt, 0);
    chk("fe_count", rxq.size(), 1);
    chk("fe_next_byte", got(0), 32'hAA);

    // Break: long low line gives a single frame error.
    clr();
    u_if.rx = 1'b0;
    idle(200);
    u_if.rx = 1'b1;
    idle(20);
    chk("brk_fe", fe_cnt, 1);
    chk("brk_valid", valid_cycles, 0);

    // Two-cycle glitch on the idle line.
    clr();
    u_if.rx = 1'b0;
    idle(2);
    u_if.rx = 1'b1;
    idle(40);
    chk("gl_valid", valid_cycles, 0);
    chk("gl_pulses", fe_cnt + ov_cnt, 0);

    // Reset in the middle of 0x3F, then 0x31.
    clr();
    u_if.rx = 1'b0;
    idle(c_cpb);
    u_if.rx = 1'b1;
    idle(2 * c_cpb);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(100);
    chk("mr_valid", valid_cycles, 0);
    chk("mr_pulses", fe_cnt + ov_cnt, 0);
    send_byte(8'h31, 1'b1);
    idle(20);
    chk("mr_count", rxq.size(), 1);
    chk("mr_byte", got(0), 32'h31);

    // Full FIFO, ready rises exactly on the fifth byte's push cycle.
    clr();
    u_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i), 1'b1);
    idle(10);
    chk("fp_full_valid", 32'(u_if.valid), 1);
    fork
      send_byte(8'h35, 1'b1);
      begin
        idle(78);
        chk("fp_no_pop_yet", rxq.size(), 0);
        u_if.ready = 1'b1;
      end
    join
    idle(20);
    chk("fp_ov", ov_cnt, 0);
    chk("fp_fe", fe_cnt, 0);
    chk("fp_count", rxq.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("fp_drain%0d", i), got(i), 32'h31 + i);
    chk("fp_valid_drop", 32'(u_if.valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, clk cycles per serial bit (50 MHz / 9600 baud); legal range 4..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, receive buffer entries; power of two, 2..16.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rx  input  1  asynchronous serial line, 8N1, LSB first, idle high; the byte stream produced by the fizzbuzz transmitter's out.
REQ-006 data  output  8  byte at FIFO head.
REQ-007 valid  output  1  FIFO not empty; data is meaningful.
REQ-008 ready  input  1  consumer accepts data when valid && ready on a rising edge.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 overrun  output  1  one-cycle pulse: completed byte dropped because FIFO full.

Function
REQ-011 rx shall pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-012 Receive FSM states shall be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-013 IDLE: on rx_s==0, go to START and clear the bit-period counter.
REQ-014 START: after CLKS_PER_BIT/2 cycles (integer division), sample rx_s; 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejected, no pulse).
REQ-015 DATA: sample rx_s every CLKS_PER_BIT cycles, eight samples, shifted in LSB first; after the 8th sample go to STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles sample rx_s; 1 -> push byte, go to IDLE; 0 -> discard byte, pulse frame_err, go to WAIT_IDLE.
REQ-017 WAIT_IDLE: stay until rx_s==1, then IDLE; a continuous low line (break) shall yield exactly one frame_err.
REQ-018 Push latency: valid/data shall reflect the byte on the cycle after the stop-bit sample cycle (if FIFO was empty).
REQ-019 FIFO shall be show-ahead: data = oldest entry whenever valid==1; data holds its value while valid && !ready.
REQ-020 Pop occurs on valid && ready; ready with valid==0 shall have no effect.
REQ-021 Push while full and no pop in the same cycle: byte dropped, FIFO unchanged, overrun pulsed that cycle.
REQ-022 Push while full with a pop in the same cycle: both succeed, occupancy unchanged, no overrun.
REQ-023 Push and pop simultaneously when not full: both succeed; push into empty FIFO with no pop makes valid 1 next cycle.
REQ-024 Read/write pointers shall wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-025 Bit-period counter width shall be clog2(CLKS_PER_BIT)+1 bits; no other arithmetic saturates or wraps visibly.
REQ-026 frame_err and overrun shall never assert in the same cycle (only STOP==1 can produce overrun; only STOP==0 frame_err).

Reset
REQ-027 While rst==1 on a rising edge: FSM to IDLE, counters, shift register and FIFO pointers/occupancy cleared, synchronizer flops set to 1.
REQ-028 Reset values: valid=0, frame_err=0, overrun=0, data=8'h00.
REQ-029 Reset mid-frame shall abandon the frame; no push, no pulse; reception restarts only on a new falling edge seen after reset release (a line already low at release enters START).

Verification (CLKS_PER_BIT=8, FIFO_DEPTH=4 unless stated)
REQ-030 Send 0x46 ('F'), ready=1 -> valid for exactly 1 cycle with data=0x46, 1 cycle after stop sample; no pulses.
REQ-031 Send "FizzBuzz\r\n" back-to-back with ready=1 -> ten bytes 46 69 7A 7A 42 75 7A 7A 0D 0A in order; no pulses.
REQ-032 ready=0, send five bytes 0x31..0x35 -> FIFO holds 31..34, overrun pulses once at 5th stop sample; then ready=1 drains 31,32,33,34 and valid drops.
REQ-033 Send 0x55 with stop bit forced low for 1 bit then high -> frame_err pulses once, no valid; following 0xAA received correctly.
REQ-034 Low glitch of 2 cycles on idle line -> no state beyond START, no valid, no pulses; assert rst during DATA of 0x3F -> no valid, next 0x31 received as 0x31.
REQ-035 Full FIFO with ready=1 asserted exactly on the 5th byte's push cycle -> no overrun, head pops, 5th byte retained; drain order correct.
